rriot_bus_arb: RTL and testbench
================================

# rriot_bus_arb

Two-master bus arbiter in front of the mcs6530 host bus port (we_n, A, DI, RS0, CS1 in; DO, OE out). The 6502 CPU has absolute priority. A debug/loader DMA master uses idle phi2 cycles to burst-read or burst-write the chip's internal RAM, I/O and timer space. The block sits between the CPU pins and the mcs6530 instance and adds no latency to CPU cycles.

## Interface
- No parameters.
- phi2  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU bus cycle valid this cycle.
- cpu_we_n, cpu_rs0, cpu_cs1  in  1 each  CPU bus controls.
- cpu_a  in  10  CPU address.
- cpu_di  in  8  CPU write data.
- dma_start  in  1  one-cycle pulse; latches dma_we_n, dma_base, dma_len.
- dma_we_n  in  1  0 = burst write, 1 = burst read.
- dma_base  in  10  first address.
- dma_len  in  6  beat count; 0 means 64.
- dma_wdata  in  8  write beat data.
- dma_wvalid  in  1  write beat available.
- dma_wready  out  1  write beat consumed this cycle.
- dma_rdata  out  8  read beat data.
- dma_rvalid  out  1  one-cycle pulse; no backpressure.
- dma_busy  out  1  burst in progress.
- dma_done  out  1  one-cycle pulse after the last beat.
- dma_err  out  1  sticky; a read beat saw OE=0. Cleared by the next accepted dma_start.
- we_n, RS0, CS1  out  1 each  to the mcs6530.
- A  out  10  to the mcs6530.
- DI  out  8  to the mcs6530.
- DO  in  8  from the mcs6530.
- OE  in  1  from the mcs6530.
- cpu_owned  out  1  combinational; equals cpu_req.

## Operation
- Output mux (combinational):
  - cpu_req=1: the bus carries the cpu_* signals unchanged.
  - cpu_req=0 and the FSM drives a DMA beat: RS0=1, CS1=0, A=current address, we_n=dma_we_n, DI=write data.
  - Otherwise (idle): we_n=1, RS0=1, CS1=1 (deselects all sub-blocks), A=0, DI=0.
- States:
  - IDLE: a dma_start pulse latches the burst fields, sets addr=dma_base and beats=len (0→64), clears dma_err, then goes to ISSUE. dma_start is ignored in every other state.
  - ISSUE, write burst: drive a beat only if cpu_req=0 and dma_wvalid=1. That cycle dma_wready=1 and the write takes effect on the edge. Then addr+1, beats−1, and go to DONE if beats reaches 0, else stay in ISSUE. If cpu_req=1 or dma_wvalid=0: no bus drive, no wready, stay in ISSUE.
  - ISSUE, read burst: if cpu_req=0, drive the address with we_n=1 and go to CAPT. Otherwise stay.
  - CAPT: hold the same address.
    - If cpu_req=0: sample DO and OE and pulse dma_rvalid. dma_rdata=DO if OE=1, else 8'h00 and dma_err is set. Then addr+1, beats−1, and go to DONE or back to ISSUE.
    - If cpu_req=1 (CPU stole the capture cycle): discard the beat and return to ISSUE with the same address. No rvalid.
  - DONE: pulse dma_done for one cycle and drop dma_busy, then go to IDLE.
- Address arithmetic: 10-bit, wraps 3FF→000. beats is a 7-bit down-counter.
- dma_busy=1 in ISSUE and CAPT; 0 in IDLE and DONE.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, dma_busy=0, dma_done=0, dma_rvalid=0, dma_err=0, dma_rdata=00. The bus outputs then follow the mux (idle values, or CPU values if cpu_req=1). Reset mid-burst abandons the burst with no done pulse.
- The CPU path is zero-latency combinational. The CPU is never stalled.
- Write beat: one cycle when granted. Full 64-beat write with no CPU traffic and wvalid held high: 64 cycles plus 1 DONE cycle.
- Read beat: two consecutive CPU-free cycles. rvalid is asserted in the CAPT cycle, i.e. one cycle after issue. Full N-beat read with no CPU traffic: 2N cycles plus 1 DONE cycle.
- dma_start arriving in the same cycle as cpu_req=1 is accepted. The first bus drive waits for cpu_req=0.

## Test plan
- Write burst: dma_base=3C0, len=4, wdata A0..A3, no CPU traffic → RAM 3C0..3C3 = A0..A3. Four wready pulses on consecutive cycles; done pulse on cycle 5.
- Read burst: read back 3C0, len=4 → rvalid on cycles 2, 4, 6, 8 with data A0..A3; done on cycle 9; dma_err=0.
- CPU steal: during a read burst, assert cpu_req in the CAPT cycle of beat 1 → CPU access completes unchanged, beat 1 is re-issued, the data sequence is still A0..A3 with no duplicate rvalid.
- Wrap and length 0: write base=3FF, len=0 → 64 beats; addresses 3FF, 000..03E; done after 64 wready pulses.
- Error: read from an address inside the decoded DMA window that no sub-block claims (OE=0 from the mcs6530) → rdata=00, dma_err=1, and the error stays set through done until the next dma_start.
- Reset mid-burst: pull rst_n low during beat 2 of a write burst → next cycle busy=0 and no done pulse; a new dma_start then runs normally.

Source files
------------

// File: rtl/rriot_bus_arb.sv
// rriot_bus_arb: two-master arbiter in front of the mcs6530 host bus port.
// The 6502 always wins; a DMA master uses CPU-free phi2 cycles to burst
// read or write the chip's RAM, I/O and timer space. The CPU path is purely
// combinational, so CPU cycles see no added latency.
module rriot_bus_arb (
  input  logic       phi2,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       cpu_we_n,
  input  logic       cpu_rs0,
  input  logic       cpu_cs1,
  input  logic [9:0] cpu_a,
  input  logic [7:0] cpu_di,
  input  logic       dma_start,
  input  logic       dma_we_n,
  input  logic [9:0] dma_base,
  input  logic [5:0] dma_len,
  input  logic [7:0] dma_wdata,
  input  logic       dma_wvalid,
  output logic       dma_wready,
  output logic [7:0] dma_rdata,
  output logic       dma_rvalid,
  output logic       dma_busy,
  output logic       dma_done,
  output logic       dma_err,
  output logic       we_n,
  output logic       RS0,
  output logic       CS1,
  output logic [9:0] A,
  output logic [7:0] DI,
  input  logic [7:0] DO,
  input  logic       OE,
  output logic       cpu_owned
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_we_n;   // latched burst direction: 1 = read
  logic [9:0]  r_addr;
  logic [6:0]  r_beats;  // remaining beats, 1..64
  logic        r_err;
  logic [7:0]  r_rdata;

  logic        w_wr_beat;
  logic        w_rd_issue;
  logic        w_capt;
  logic        w_drive;
  logic        w_last;
  logic [7:0]  w_beat_data;

  // Beat qualification: every DMA bus drive requires a CPU-free cycle.
  assign w_wr_beat   = (r_state == S_ISSUE) && !r_we_n && !cpu_req && dma_wvalid;
  assign w_rd_issue  = (r_state == S_ISSUE) &&  r_we_n && !cpu_req;
  assign w_capt      = (r_state == S_CAPT)  && !cpu_req;
  assign w_drive     = w_wr_beat || w_rd_issue || w_capt;
  assign w_last      = (r_beats == 7'd1);
  assign w_beat_data = OE ? DO : 8'h00;

  assign cpu_owned   = cpu_req;
  assign dma_wready  = w_wr_beat;
  assign dma_rvalid  = w_capt;
  // Captured data is presented in the capture cycle itself, then held.
  assign dma_rdata   = w_capt ? w_beat_data : r_rdata;
  // An unclaimed read flags the error in the same cycle as its rvalid.
  assign dma_err     = r_err || (w_capt && !OE);
  assign dma_busy    = (r_state == S_ISSUE) || (r_state == S_CAPT);
  assign dma_done    = (r_state == S_DONE);

  // Bus output mux: CPU passthrough, DMA beat, or deselected idle.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    we_n = 1'b1;
    RS0  = 1'b1;
    CS1  = 1'b1;
    A    = 10'd0;
    DI   = 8'd0;
    if (cpu_req) begin
      we_n = cpu_we_n;
      RS0  = cpu_rs0;
      CS1  = cpu_cs1;
      A    = cpu_a;
      DI   = cpu_di;
    end else if (w_drive) begin
      we_n = r_we_n;
      RS0  = 1'b1;
      CS1  = 1'b0;
      A    = r_addr;
      DI   = dma_wdata;
    end
  end

  // Burst sequencer: latches the request, steps address/beat count per beat.
  always_ff @(posedge phi2) begin
    // NOTE: reset is sampled on the clock edge; state uses non-blocking
    // assignments so every branch reads the pre-edge register values.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we_n  <= 1'b1;
      r_addr  <= 10'd0;
      r_beats <= 7'd0;
      r_err   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dma_start) begin
            r_we_n  <= dma_we_n;
            r_addr  <= dma_base;
            r_beats <= (dma_len == 6'd0) ? 7'd64 : {1'b0, dma_len};
            r_err   <= 1'b0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_wr_beat) begin
            r_addr  <= r_addr + 10'd1;
            r_beats <= r_beats - 7'd1;
            r_state <= w_last ? S_DONE : S_ISSUE;
          end else if (w_rd_issue) begin
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (!cpu_req) begin
            r_rdata <= w_beat_data;
            if (!OE) r_err <= 1'b1;
            r_addr  <= r_addr + 10'd1;
            r_beats <= r_beats - 7'd1;
            r_state <= w_last ? S_DONE : S_ISSUE;
          end else begin
            // CPU stole the capture cycle: re-issue the same address.
            r_state <= S_ISSUE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rriot_bus_arb.sv
// Directed bench for rriot_bus_arb with a behavioural mcs6530 bus model.
// Inputs change on the falling edge; outputs are checked 2 ns later.
module tb_rriot_bus_arb;

  logic       phi2 = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we_n, cpu_rs0, cpu_cs1;
  logic [9:0] cpu_a;
  logic [7:0] cpu_di;
  logic       dma_start, dma_we_n;
  logic [9:0] dma_base;
  logic [5:0] dma_len;
  logic [7:0] dma_wdata;
  logic       dma_wvalid, dma_wready;
  logic [7:0] dma_rdata;
  logic       dma_rvalid, dma_busy, dma_done, dma_err;
  logic       we_n, RS0, CS1;
  logic [9:0] A;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       OE;
  logic       cpu_owned;

  int n_checks = 0;
  int n_pass   = 0;

  rriot_bus_arb dut (
    .phi2(phi2), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we_n(cpu_we_n), .cpu_rs0(cpu_rs0), .cpu_cs1(cpu_cs1),
    .cpu_a(cpu_a), .cpu_di(cpu_di),
    .dma_start(dma_start), .dma_we_n(dma_we_n), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_busy(dma_busy),
    .dma_done(dma_done), .dma_err(dma_err),
    .we_n(we_n), .RS0(RS0), .CS1(CS1), .A(A), .DI(DI), .DO(DO), .OE(OE),
    .cpu_owned(cpu_owned)
  );

  always #5 phi2 = ~phi2;

  // mcs6530 model: synchronous write, registered read; 200..2FF is unclaimed.
  logic [7:0] mem [0:1023];
  always @(posedge phi2) begin
    if (!CS1 && RS0 && !we_n) mem[A] <= DI;
    DO <= mem[A];
    OE <= !CS1 && (A[9:8] != 2'b10);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(negedge phi2);
  endtask

  // Pulse dma_start; returns at the start of the first cycle after acceptance.
  task automatic start_burst(input logic we, input logic [9:0] base, input logic [5:0] len);
    next_cycle();
    dma_start = 1'b1;
    dma_we_n  = we;
    dma_base  = base;
    dma_len   = len;
    next_cycle();
    dma_start = 1'b0;
  endtask

  initial begin
    int nbeat;
    int nready;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we_n = 1'b1; cpu_rs0 = 1'b0; cpu_cs1 = 1'b0;
    cpu_a = 10'd0; cpu_di = 8'd0; dma_start = 1'b0; dma_we_n = 1'b1;
    dma_base = 10'd0; dma_len = 6'd0; dma_wdata = 8'd0; dma_wvalid = 1'b0;

    // Reset state and idle bus values.
    next_cycle(); #2;
    check("rst_busy",  dma_busy,   1'b0);
    check("rst_done",  dma_done,   1'b0);
    check("rst_rvalid",dma_rvalid, 1'b0);
    check("rst_err",   dma_err,    1'b0);
    check("rst_rdata", dma_rdata,  8'h00);
    check("idle_bus",  {we_n, RS0, CS1, A, DI}, {3'b111, 10'd0, 8'd0});
    check("idle_own",  cpu_owned,  1'b0);
    // CPU passthrough while idle.
    cpu_req = 1'b1; cpu_we_n = 1'b0; cpu_rs0 = 1'b0; cpu_cs1 = 1'b1;
    cpu_a = 10'h2A5; cpu_di = 8'h3C; #1;
    check("cpu_pass",  {we_n, RS0, CS1, A, DI}, {3'b001, 10'h2A5, 8'h3C});
    check("cpu_own",   cpu_owned,  1'b1);
    next_cycle();
    cpu_req = 1'b0; cpu_we_n = 1'b1; rst_n = 1'b1;

    // Write burst 3C0, len 4, data A0..A3.
    start_burst(1'b0, 10'h3C0, 6'd4);
    dma_wvalid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) next_cycle();
      dma_wdata = 8'hA0 + 8'(c - 1);
      #2;
      if (c <= 4) begin
        check("wr_ready", dma_wready, 1'b1);
        check("wr_bus",   {we_n, RS0, CS1, A, DI}, {3'b010, 10'h3C0 + 10'(c - 1), 8'hA0 + 8'(c - 1)});
        check("wr_busy",  dma_busy, 1'b1);
        check("wr_nodone",dma_done, 1'b0);
      end else begin
        check("wr_done",    dma_done,   1'b1);
        check("wr_done_bsy",dma_busy,   1'b0);
        check("wr_done_rdy",dma_wready, 1'b0);
      end
    end
    next_cycle(); dma_wvalid = 1'b0; #2;
    check("wr_done_pulse", dma_done, 1'b0);
    for (int i = 0; i < 4; i++) check("wr_mem", mem[10'h3C0 + 10'(i)], 8'hA0 + 8'(i));

    // Read burst 3C0, len 4: rvalid on even cycles, done on cycle 9.
    start_burst(1'b1, 10'h3C0, 6'd4);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) next_cycle();
      #2;
      if (c == 9) begin
        check("rd_done", dma_done, 1'b1);
        check("rd_err",  dma_err,  1'b0);
      end else if (c % 2 == 1) begin
        check("rd_issue_rv", dma_rvalid, 1'b0);
        check("rd_issue_bus", {we_n, CS1, A}, {2'b10, 10'h3C0 + 10'((c - 1) / 2)});
      end else begin
        check("rd_rvalid", dma_rvalid, 1'b1);
        check("rd_data",   dma_rdata,  8'hA0 + 8'((c - 2) / 2));
      end
    end

    // CPU steals the capture cycle of beat 1 (cycle 4).
    start_burst(1'b1, 10'h3C0, 6'd4);
    nbeat = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) next_cycle();
      cpu_req = (c == 4); cpu_we_n = 1'b1; cpu_rs0 = 1'b0; cpu_cs1 = 1'b1;
      cpu_a = 10'h155; cpu_di = 8'h5A;
      #2;
      if (c == 4) begin
        check("steal_bus", {we_n, RS0, CS1, A, DI}, {3'b101, 10'h155, 8'h5A});
        check("steal_norv", dma_rvalid, 1'b0);
      end
      if (c == 5) check("steal_reissue", A, 10'h3C1);
      if (dma_rvalid) begin
        check("steal_data", dma_rdata, 8'hA0 + 8'(nbeat));
        nbeat++;
      end
      if (c == 11) check("steal_done", dma_done, 1'b1);
    end
    cpu_req = 1'b0;
    check("steal_beats", nbeat, 4);

    // Wrap and length 0: base 3FF, 64 beats.
    start_burst(1'b0, 10'h3FF, 6'd0);
    dma_wvalid = 1'b1;
    nready = 0;
    for (int c = 1; c <= 65; c++) begin
      if (c > 1) next_cycle();
      dma_wdata = 8'h40 + 8'(c - 1);
      #2;
      if (dma_wready) nready++;
      if (c == 1)  check("wrap_a0",  A, 10'h3FF);
      if (c == 2)  check("wrap_a1",  A, 10'h000);
      if (c == 64) check("wrap_a63", A, 10'h03E);
      if (c == 64) check("wrap_nodone", dma_done, 1'b0);
      if (c == 65) check("wrap_done", dma_done, 1'b1);
    end
    dma_wvalid = 1'b0;
    check("wrap_beats", nready, 64);
    next_cycle();
    check("wrap_m3ff", mem[10'h3FF], 8'h40);
    check("wrap_m000", mem[10'h000], 8'h41);
    check("wrap_m03e", mem[10'h03E], 8'h7F);

    // Error: read from unclaimed 200, len 2.
    start_burst(1'b1, 10'h200, 6'd2);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) next_cycle();
      #2;
      if (c == 2) begin
        check("err_rv",    dma_rvalid, 1'b1);
        check("err_rdata", dma_rdata,  8'h00);
        check("err_flag",  dma_err,    1'b1);
      end
      if (c == 5) check("err_done", dma_done, 1'b1);
      if (c >= 3) check("err_sticky", dma_err, 1'b1);
    end
    start_burst(1'b1, 10'h3C0, 6'd1);
    #2;
    check("err_clear", dma_err, 1'b0);
    next_cycle(); #2;
    check("err_clr_data", dma_rdata, 8'hA0);
    next_cycle(); #2;
    check("err_clr_done", dma_done, 1'b1);

    // Reset during beat 2 of a write burst.
    start_burst(1'b0, 10'h100, 6'd4);
    dma_wvalid = 1'b1; dma_wdata = 8'h11;
    #2;
    check("rst_b1_ready", dma_wready, 1'b1);
    next_cycle(); rst_n = 1'b0; dma_wdata = 8'h22;
    next_cycle(); rst_n = 1'b1; dma_wvalid = 1'b0; #2;
    check("rstm_busy", dma_busy, 1'b0);
    check("rstm_done", dma_done, 1'b0);
    check("rstm_bus",  {we_n, RS0, CS1, A}, {3'b111, 10'd0});
    next_cycle(); #2;
    check("rstm_nodone", dma_done, 1'b0);
    start_burst(1'b0, 10'h100, 6'd2);
    dma_wvalid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) next_cycle();
      dma_wdata = 8'h55 + 8'(c);
      #2;
      if (c <= 2) check("rstm_ready", dma_wready, 1'b1);
      else        check("rstm_redone", dma_done, 1'b1);
    end
    dma_wvalid = 1'b0;
    next_cycle();
    check("rstm_mem", mem[10'h101], 8'h57);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
